// File: rtl/capture_ctrl.sv
// Capture controller: arms a circular sample buffer, waits for a trigger,
// collects post-trigger samples, then streams the buffer oldest-first.
module capture_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trigger,
    input  logic [ADDR_WIDTH-1:0] post_len,
    input  logic                  primed,
    input  logic [ADDR_WIDTH-1:0] waddr,
    output logic                  write_enable,
    output logic                  buf_reset,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FILL,
        WAIT_TRIG,
        POST,
        READ
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ZERO = '0;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pcnt;
    logic [ADDR_WIDTH-1:0] rcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pcnt      <= ZERO;
            rcnt      <= ZERO;
            raddr     <= ZERO;
            trig_addr <= ZERO;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (arm && !abort) begin
                            state <= CLEAR;
                            pcnt  <= post_len;
                        end
                    end
                    CLEAR: state <= FILL;
                    FILL: begin
                        if (primed)
                            state <= WAIT_TRIG;
                    end
                    WAIT_TRIG: begin
                        if (trigger) begin
                            state     <= POST;
                            trig_addr <= waddr;
                        end
                    end
                    POST: begin
                        // waddr now points at the oldest sample in the full ring
                        if (pcnt != ZERO) begin
                            pcnt <= pcnt - ONE;
                        end else begin
                            state <= READ;
                            raddr <= waddr;
                            rcnt  <= ZERO;
                        end
                    end
                    READ: begin
                        if (out_ready) begin
                            raddr <= raddr + ONE;
                            rcnt  <= rcnt + ONE;
                            if (rcnt == LAST) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign write_enable = (state == FILL) || (state == WAIT_TRIG)
                       || (state == POST && pcnt != ZERO);
    assign buf_reset    = (state == CLEAR);
    assign out_valid    = (state == READ);
    assign out_last     = (state == READ) && (rcnt == LAST);
    assign busy         = (state != IDLE);
    assign out_data     = rd_data;

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: buffer address width; buffer depth N = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 8: sample width.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 arm  in  1  start-capture request; sampled only in IDLE.
REQ-006 abort  in  1  cancel request; sampled in every state.
REQ-007 trigger  in  1  qualified trigger condition.
REQ-008 post_len  in  ADDR_WIDTH  post-trigger sample count; latched on accepted arm.
REQ-009 primed  in  1  buffer-fully-written flag from the write side.
REQ-010 waddr  in  ADDR_WIDTH  current write address from the write side.
REQ-011 write_enable  out  1  buffer write enable.
REQ-012 buf_reset  out  1  synchronous reset to the write side (waddr, primed).
REQ-013 raddr  out  ADDR_WIDTH  buffer read address.
REQ-014 rd_data  in  DATA_WIDTH  combinational buffer read data at raddr.
REQ-015 out_valid / out_ready  out / in  1 / 1  readout stream handshake.
REQ-016 out_data  out  DATA_WIDTH  readout sample, equal to rd_data.
REQ-017 out_last  out  1  marks the final (N-th) readout sample.
REQ-018 trig_addr  out  ADDR_WIDTH  buffer address of the trigger sample.
REQ-019 busy  out  1  high whenever state != IDLE.
REQ-020 done  out  1  one-cycle pulse on completion of readout.

Function
REQ-021 States: IDLE, CLEAR, FILL, WAIT_TRIG, POST, READ; state register, counters, raddr and trig_addr are all registered.
REQ-022 IDLE: arm=1 and abort=0 -> CLEAR; latch post_len into post counter pcnt.
REQ-023 CLEAR: buf_reset=1 for exactly this one cycle, write_enable=0 -> FILL.
REQ-024 FILL: write_enable=1; trigger ignored; primed=1 -> WAIT_TRIG.
REQ-025 WAIT_TRIG: write_enable=1; trigger=1 -> POST, trig_addr <= waddr (address written in that cycle).
REQ-026 POST: write_enable=(pcnt!=0); pcnt decrements each cycle while nonzero; pcnt==0 -> READ, raddr <= waddr (oldest sample).
REQ-027 Exactly post_len samples follow the trigger sample; post_len=0 stores the trigger sample as the newest entry; max post_len = N-1 guarantees the trigger sample is retained.
REQ-028 READ: write_enable=0; out_valid=1; out_data=rd_data; readout counter rcnt starts at 0.
REQ-029 Transfer = out_valid & out_ready; on transfer raddr <= raddr+1 (modulo N wrap) and rcnt <= rcnt+1.
REQ-030 With out_valid=1 and out_ready=0, raddr, out_data and out_last hold; out_valid never drops before transfer.
REQ-031 out_last = READ & (rcnt == N-1); transfer with out_last -> IDLE with done=1 in the following cycle.
REQ-032 Readout order is oldest to newest; sample k (0-based) is read from address (waddr_at_READ_entry + k) mod N.
REQ-033 abort=1 in any non-IDLE state -> IDLE next cycle; write_enable=0, out_valid=0, done=0; trig_addr retains its last value.
REQ-034 arm and abort asserted together in IDLE: abort wins; state stays IDLE.
REQ-035 arm outside IDLE is ignored; post_len changes outside IDLE have no effect.
REQ-036 trigger asserted in the same cycle as FILL->WAIT_TRIG is ignored; only triggers sampled in WAIT_TRIG count.
REQ-037 write_enable, buf_reset, out_valid, out_last and busy are decoded from registered state/counters only (no input-to-output combinational path); out_data is the only exception, being the direct rd_data pass-through.

Reset
REQ-038 reset=1 -> state IDLE, write_enable=0, buf_reset=0, out_valid=0, out_last=0, done=0, busy=0, raddr=0, trig_addr=0, pcnt=0, rcnt=0 on next edge.
REQ-039 reset takes priority over abort, arm and any handshake.
REQ-040 reset mid-READ drops out_valid with no done pulse.

Verification (ADDR_WIDTH=4, N=16)
REQ-041 arm with post_len=3, trigger held 1 -> CLEAR 1 cycle; 16 FILL writes; trig_addr = waddr at trigger; write_enable drops 3 cycles later; 16 samples out, trigger sample is the 13th (k=12).
REQ-042 out_ready toggled 1,0,0,1 repeating during READ -> no sample lost or duplicated; out_data stable while stalled; out_last only on the 16th transfer; done 1 cycle after it.
REQ-043 post_len=0 -> trigger sample is the 16th (last) readout sample; post_len=15 -> trigger sample is the 1st.
REQ-044 abort in FILL, WAIT_TRIG, POST and READ -> IDLE next cycle, write_enable=0, out_valid=0, no done; a subsequent arm completes normally.
REQ-045 arm and abort in the same cycle -> stays IDLE; trigger pulse during FILL or on the FILL->WAIT_TRIG edge -> ignored.
REQ-046 reset asserted mid-POST -> all outputs at reset values next cycle; waddr wrap during READ (raddr 15 -> 0) verified.
